// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory arbiter: default geometry, the
// arbiter state encoding and the requester port identifiers.
// -----------------------------------------------------------------------------
package dmem_pkg;

    // Default geometry: 256 words of 32 bits, 32-bit word addresses.
    localparam int DEPTH_DEF = 256;
    localparam int AW_DEF    = 32;
    localparam int DW_DEF    = 32;

    // Arbiter state encoding: IDLE -> ACCESS -> DONE -> IDLE.
    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t ACCESS = 2'd1;
    localparam state_t DONE   = 2'd2;

    // Requester identifiers: port 0 is the CPU load/store unit,
    // port 1 is the loader/debug port.
    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant logic, purely combinational.
//
// Ports:
//   req      in   2  request vector, bit 0 = port 0, bit 1 = port 1
//   last_gnt in   1  id of the port that was served most recently
//   gnt      out  2  one-hot grant, zero when nothing is requested
//   gnt_id   out  1  id of the granted port (port 0 when nothing requested)
// -----------------------------------------------------------------------------
module rr_arb2
    import dmem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    always_comb begin
        gnt_id = P0;
        case (req)
            2'b01:   gnt_id = P0;
            2'b10:   gnt_id = P1;
            // Contention: the port that did not go last wins.
            2'b11:   gnt_id = ~last_gnt;
            default: gnt_id = P0;
        endcase
    end

    always_comb begin
        gnt = 2'b00;
        if (req != 2'b00) begin
            gnt = (gnt_id == P1) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Arbiter and sequencer in front of the single-port data memory. Two
// requesters share the memory; every access runs a fixed three-cycle
// sequence IDLE -> ACCESS -> DONE so that read and write enables are never
// asserted together and each requester sees a single-cycle done pulse with
// registered read data.
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   p0_req/p0_we           port 0 request (held until done) and write select
//   p0_addr/p0_wdata       port 0 word address and write data
//   p0_done/p0_err         port 0 completion pulse and out-of-range flag
//   p0_rdata               port 0 read data, held until its next read
//   p1_*                   same set for port 1
//   mem_ren/mem_wen        memory read / write enables (ACCESS only)
//   mem_addr/mem_wdata     memory address and write data
//   mem_rdata              memory read data, combinational from mem_addr
//   busy                   high while a transaction is in flight
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_done,
    output logic          p0_err,
    output logic [DW-1:0] p0_rdata,

    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_done,
    output logic          p1_err,
    output logic [DW-1:0] p1_rdata,

    output logic          mem_ren,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    function automatic logic addr_in_range(input logic [AW-1:0] a);
        return a < AW'(DEPTH);
    endfunction

    state_t        state;
    logic          last_gnt;

    // Transaction context latched at grant time.
    logic          cur_id;
    logic          cur_we;
    logic          cur_oor;

    // Arbitration.
    logic [1:0]    req;
    logic [1:0]    gnt;
    logic          gnt_id;
    logic          grant;

    // Request fields of the port being granted this cycle.
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_oor;

    assign req   = {p1_req, p0_req};
    assign grant = (state == IDLE) && (gnt != 2'b00);
    assign busy  = (state != IDLE);

    rr_arb2 u_arb (
        .req      (req),
        .last_gnt (last_gnt),
        .gnt      (gnt),
        .gnt_id   (gnt_id)
    );

    always_comb begin
        sel_we    = p0_we;
        sel_addr  = p0_addr;
        sel_wdata = p0_wdata;
        if (gnt_id == P1) begin
            sel_we    = p1_we;
            sel_addr  = p1_addr;
            sel_wdata = p1_wdata;
        end
    end

    assign sel_oor = !addr_in_range(sel_addr);

    // The memory-side signals are registered at the grant edge, so they are
    // valid for exactly the ACCESS cycle and drop immediately on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_gnt  <= P1;
            cur_id    <= P0;
            cur_we    <= 1'b0;
            cur_oor   <= 1'b0;
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            p0_done   <= 1'b0;
            p0_err    <= 1'b0;
            p0_rdata  <= '0;
            p1_done   <= 1'b0;
            p1_err    <= 1'b0;
            p1_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        cur_id  <= gnt_id;
                        cur_we  <= sel_we;
                        cur_oor <= sel_oor;
                        // Out-of-range accesses never touch the memory.
                        if (!sel_oor) begin
                            mem_addr  <= sel_addr;
                            mem_wdata <= sel_wdata;
                            mem_wen   <= sel_we;
                            mem_ren   <= ~sel_we;
                        end
                        state <= ACCESS;
                    end
                end

                ACCESS: begin
                    mem_ren <= 1'b0;
                    mem_wen <= 1'b0;
                    // Read data and the done/err pulse become visible in DONE;
                    // an out-of-range read returns zero.
                    if (cur_id == P0) begin
                        p0_done <= 1'b1;
                        p0_err  <= cur_oor;
                        if (!cur_we) begin
                            p0_rdata <= cur_oor ? '0 : mem_rdata;
                        end
                    end else begin
                        p1_done <= 1'b1;
                        p1_err  <= cur_oor;
                        if (!cur_we) begin
                            p1_rdata <= cur_oor ? '0 : mem_rdata;
                        end
                    end
                    state <= DONE;
                end

                DONE: begin
                    p0_done  <= 1'b0;
                    p0_err   <= 1'b0;
                    p1_done  <= 1'b0;
                    p1_err   <= 1'b0;
                    last_gnt <= cur_id;
                    state    <= IDLE;
                end

                default: begin
                    mem_ren <= 1'b0;
                    mem_wen <= 1'b0;
                    p0_done <= 1'b0;
                    p0_err  <= 1'b0;
                    p1_done <= 1'b0;
                    p1_err  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a 256-word behavioural memory.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_done, p0_err, p1_done, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_ren, mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    logic [31:0] mem [0:255];
    logic        mem_clr;
    logic        poke_en;
    logic [7:0]  poke_addr;
    logic [31:0] poke_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_done   (p0_done),
        .p0_err    (p0_err),
        .p0_rdata  (p0_rdata),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_done   (p1_done),
        .p1_err    (p1_err),
        .p1_rdata  (p1_rdata),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    assign mem_rdata = (mem_addr < 32'd256) ? mem[mem_addr[7:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else if (mem_wen) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end else if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory-side invariants, checked every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            chk("en_exclusive", {31'b0, mem_ren & mem_wen}, 32'h0);
            chk("en_only_busy", {31'b0, (mem_ren | mem_wen) & ~busy}, 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        tick();
        poke_en   = 1'b0;
    endtask

    task automatic drive(input logic port, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 1'b0) begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t        vecs [12];
    vec_t        v;
    logic [31:0] r0, r1;
    logic        w;
    logic        d0, d1;

    initial begin
        rst = 1'b1;  mem_clr = 1'b1;  poke_en = 1'b0;
        poke_addr = '0;  poke_data = '0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        mem_clr = 1'b0;
        poke(8'd1, 32'h1111_0001);
        poke(8'd7, 32'h7777_0007);
        poke(8'd9, 32'h9999_0009);

        // Reset state.
        chk("rst busy",      busy,      32'h0);
        chk("rst mem_ren",   mem_ren,   32'h0);
        chk("rst mem_wen",   mem_wen,   32'h0);
        chk("rst mem_addr",  mem_addr,  32'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        chk("rst p0_done",   p0_done,   32'h0);
        chk("rst p1_done",   p1_done,   32'h0);
        chk("rst p0_rdata",  p0_rdata,  32'h0);
        chk("rst p1_rdata",  p1_rdata,  32'h0);
        rst = 1'b0;
        tick();

        //             port  we    addr     wdata         err   rdata
        vecs[0]  = '{1'b0, 1'b1, 32'd5,   32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'd5,   32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 1'b1, 32'd2,   32'h2222_2222, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'd2,   32'h0,        1'b0, 32'h2222_2222};
        vecs[4]  = '{1'b1, 1'b0, 32'd300, 32'h0,        1'b1, 32'h0};
        vecs[5]  = '{1'b1, 1'b1, 32'd300, 32'h0BAD_F00D, 1'b1, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 32'd44,  32'h0,        1'b0, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 32'd255, 32'hFFFF_0000, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 32'd255, 32'h0,        1'b0, 32'hFFFF_0000};
        vecs[9]  = '{1'b0, 1'b0, 32'd256, 32'h0,        1'b1, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 32'd5,   32'h0,        1'b0, 32'hDEADBEEF};
        vecs[11] = '{1'b0, 1'b0, 32'd1,   32'h0,        1'b0, 32'h1111_0001};

        r0 = 32'h0;
        r1 = 32'h0;
        for (int i = 0; i < 12; i++) begin
            v = vecs[i];
            drive(v.port, 1'b1, v.we, v.addr, v.wdata);
            tick();
            // ACCESS cycle
            chk($sformatf("v%0d busy", i),    busy,    32'h1);
            chk($sformatf("v%0d mem_ren", i), mem_ren, {31'b0, ~v.we & ~v.err});
            chk($sformatf("v%0d mem_wen", i), mem_wen, {31'b0, v.we & ~v.err});
            if (!v.err) chk($sformatf("v%0d mem_addr", i), mem_addr, v.addr);
            if (v.we && !v.err) chk($sformatf("v%0d mem_wdata", i), mem_wdata, v.wdata);
            chk($sformatf("v%0d early_done", i), {31'b0, p0_done | p1_done}, 32'h0);
            tick();
            // DONE cycle
            if (!v.we) begin
                if (v.port == 1'b0) r0 = v.rdata;
                else                r1 = v.rdata;
            end
            chk($sformatf("v%0d p0_done", i), p0_done, {31'b0, ~v.port});
            chk($sformatf("v%0d p1_done", i), p1_done, {31'b0, v.port});
            chk($sformatf("v%0d err", i), v.port ? p1_err : p0_err, {31'b0, v.err});
            chk($sformatf("v%0d p0_rdata", i), p0_rdata, r0);
            chk($sformatf("v%0d p1_rdata", i), p1_rdata, r1);
            drive(v.port, 1'b0, 1'b0, 32'h0, 32'h0);
            tick();
            chk($sformatf("v%0d idle_done", i), {31'b0, p0_done | p1_done}, 32'h0);
            chk($sformatf("v%0d idle_busy", i), busy, 32'h0);
        end

        // Reset in the middle of a port 0 write.
        drive(1'b0, 1'b1, 1'b1, 32'd10, 32'hA5A5_A5A5);
        tick();
        chk("midrst wen_before", mem_wen, 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("midrst mem_wen",   mem_wen,   32'h0);
        chk("midrst mem_ren",   mem_ren,   32'h0);
        chk("midrst mem_addr",  mem_addr,  32'h0);
        chk("midrst mem_wdata", mem_wdata, 32'h0);
        chk("midrst busy",      busy,      32'h0);
        chk("midrst p0_rdata",  p0_rdata,  32'h0);
        chk("midrst p1_rdata",  p1_rdata,  32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("midrst no_done", {31'b0, p0_done | p1_done}, 32'h0);
        rst = 1'b0;
        tick();

        // Tie after reset: port 0 first (done at N+2), then port 1 (N+5).
        drive(1'b0, 1'b1, 1'b0, 32'd1, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'd2, 32'h0);
        tick();
        chk("tie acc1 mem_ren",  mem_ren,  32'h1);
        chk("tie acc1 mem_addr", mem_addr, 32'd1);
        tick();
        chk("tie p0_done",  p0_done,  32'h1);
        chk("tie p1_wait",  p1_done,  32'h0);
        chk("tie p0_rdata", p0_rdata, 32'h1111_0001);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("tie gap_done", {31'b0, p0_done | p1_done}, 32'h0);
        tick();
        chk("tie acc2 mem_addr", mem_addr, 32'd2);
        tick();
        chk("tie p1_done",   p1_done,  32'h1);
        chk("tie p1_rdata",  p1_rdata, 32'h2222_2222);
        chk("tie p0_hold",   p0_rdata, 32'h1111_0001);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // Continuous contention: grants alternate p0, p1, ...
        r0 = 32'h1111_0001;
        r1 = 32'h2222_2222;
        drive(1'b0, 1'b1, 1'b0, 32'd7, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'd9, 32'h0);
        for (int k = 0; k < 18; k++) begin
            tick();
            w  = ((k / 3) % 2) != 0;
            d0 = ((k % 3) == 1) && !w;
            d1 = ((k % 3) == 1) && w;
            if (d0) r0 = 32'h7777_0007;
            if (d1) r1 = 32'h9999_0009;
            chk($sformatf("rr k%0d p0_done", k), p0_done, {31'b0, d0});
            chk($sformatf("rr k%0d p1_done", k), p1_done, {31'b0, d1});
            chk($sformatf("rr k%0d p0_rdata", k), p0_rdata, r0);
            chk($sformatf("rr k%0d p1_rdata", k), p1_rdata, r1);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // Request dropped and address changed after the grant.
        poke(8'd7, 32'h0707_0707);
        drive(1'b0, 1'b1, 1'b0, 32'd7, 32'h0);
        tick();
        chk("drop mem_addr", mem_addr, 32'd7);
        chk("drop mem_ren",  mem_ren,  32'h1);
        drive(1'b0, 1'b0, 1'b0, 32'd9, 32'h0);
        tick();
        chk("drop p0_done",  p0_done,  32'h1);
        chk("drop p0_rdata", p0_rdata, 32'h0707_0707);
        tick();
        chk("drop done_end", p0_done, 32'h0);
        chk("drop busy_end", busy,    32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbiter and sequencer in front of the single-port 256x32 data memory.
- Shares that memory between two requesters: port 0 is the CPU load/store unit, port 1 is the loader/debug port.
- Serialises accesses and guarantees the memory never sees read and write enables together, which would return 0.
- Registers read data so requesters see a clean, one-pulse completion handshake.

Parameters:
- DEPTH, 256, number of 32-bit memory words; valid addresses are 0..DEPTH-1.
- AW, 32, address width of requester and memory ports.
- DW, 32, data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- p0_req  in  1  port 0 request; held high until p0_done.
- p0_we  in  1  port 0 access type: 1 = write, 0 = read.
- p0_addr  in  AW  port 0 word address.
- p0_wdata  in  DW  port 0 write data.
- p0_done  out  1  port 0 completion pulse, one cycle.
- p0_err  out  1  port 0 out-of-range flag, valid with p0_done.
- p0_rdata  out  DW  port 0 read data, valid from p0_done until port 0's next read completes.
- p1_req, p1_we, p1_addr, p1_wdata, p1_done, p1_err, p1_rdata: same as port 0, for port 1.
- mem_ren  out  1  memory read enable.
- mem_wen  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, combinational from mem_addr.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, last_gnt=1 (port 0 wins first tie).
  - mem_ren=0, mem_wen=0, mem_addr=0, mem_wdata=0.
  - Both done/err/rdata outputs = 0; busy=0.
- FSM states: IDLE -> ACCESS -> DONE -> IDLE. Fixed 3-cycle transaction; throughput 1 access per 3 cycles.
- IDLE:
  - No req: stay IDLE.
  - Single req: grant that port.
  - Both req: grant the port != last_gnt (round-robin).
  - On grant: latch id, we, addr, wdata; go ACCESS.
- ACCESS, one cycle:
  - If latched addr >= DEPTH: both enables stay 0 and err is set.
  - Else drive mem_addr/mem_wdata from the latched values, with exactly one of mem_wen (we=1) or mem_ren (we=0) high.
  - Reads: capture mem_rdata into the winner's rdata register at the clock edge ending ACCESS.
  - Go DONE.
- DONE:
  - Enables=0.
  - Pulse winner's done for one cycle; err asserted with it if out-of-range.
  - Out-of-range read sets rdata=0; out-of-range write leaves memory untouched.
  - last_gnt <= winner; go IDLE.
- Latency: req seen in IDLE at cycle N -> done high at cycle N+2.
- Invariants:
  - mem_ren & mem_wen never both 1.
  - Enables are only high in ACCESS.
  - Only the granted port's done/rdata change.
- Requester drops req before done: transaction still completes from latched values and done still pulses.
- Requester changes addr/wdata mid-transaction: ignored, because values are latched.
- Same port re-requests in the cycle after done: arbitrated normally in IDLE; the other port wins if it is also requesting.
- Reset mid-transaction: abort immediately. Any write already asserted in ACCESS is not guaranteed. No done pulse; arbitration restarts from port 0.
- Non-winner's rdata holds its previous value through other transactions.

Decomposition:
- Shared package dmem_pkg:
  - state enum {IDLE, ACCESS, DONE};
  - DEPTH/AW/DW defaults;
  - port-id constants P0=0, P1=1.
- Sub-module rr_arb2: 2-way round-robin grant logic, combinational. Inputs: req[1:0], last_gnt. Outputs: gnt onehot, gnt_id.

Test Plan:
1. Reset: assert rst mid-ACCESS of a p0 write -> mem_wen drops the same cycle; all outputs 0; busy=0; next tie grants p0.
2. p0 write addr=5, wdata=0xDEADBEEF in IDLE at cycle N:
   - -> mem_wen=1, mem_addr=5 at N+1;
   - p0_done pulse at N+2, p0_err=0;
   - subsequent p0 read addr=5 -> p0_rdata=0xDEADBEEF with p0_done.
3. Simultaneous p0 read addr=1 and p1 read addr=2 after reset, both held:
   - -> p0 served first, done at N+2;
   - p1 served next, done at N+5;
   - mem_ren never coincides with mem_wen.
4. Continuous requests from both ports for 6 transactions -> grants alternate p0,p1,p0,p1,p0,p1; p1_rdata unchanged during p0 transactions.
5. p1 read addr=300 (>= DEPTH) -> mem_ren/mem_wen stay 0; p1_done=1 with p1_err=1 and p1_rdata=0. Same for a write: memory contents unchanged.
6. p0 read addr=7 with req dropped after 1 cycle and addr changed to 9 -> access uses addr 7; p0_done still pulses with RAM[7].
